// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver producing the 11-bit toggle-word key
// event {toggle, pressed, extended, code[7:0]}.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_key_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk_sys,
  input  logic        RESET_L,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      FLT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          flt_lvl_q, flt_lvl_d;
  logic [7:0]    flt_cnt_q, flt_cnt_d;
  logic          strobe_q, strobe_d;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          deliver;
  logic          drop;
  logic          par_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif

  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [2:0]    skip_q, skip_d;
  logic [10:0]   key_q, key_d;
  logic          kv_q, kv_d;
  logic          fe_q, fe_d;

  // Synchronise both lines and debounce the clock; strobe on accepted fall.
  always_comb begin
    clk_s1_d  = ps2_clk;
    clk_s2_d  = clk_s1_q;
    dat_s1_d  = ps2_data;
    dat_s2_d  = dat_s1_q;
    flt_lvl_d = flt_lvl_q;
    flt_cnt_d = '0;
    strobe_d  = 1'b0;
    if (clk_s2_q != flt_lvl_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        flt_lvl_d = clk_s2_q;
        strobe_d  = ~clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 8'd1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Frame FSM: start, 8 data bits LSB first, parity, stop; plus timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    deliver   = 1'b0;
    drop      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (strobe_q && !dat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (strobe_q) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (strobe_q) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = dat_s2_q;
`endif
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strobe_q) begin
          state_d = ST_IDLE;
          if (dat_s2_q && par_ok) deliver = 1'b1;
          else                    drop    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The strobe clears the counter first, so a stop strobe never meets a timeout.
    if (state_q == ST_IDLE) begin
      to_cnt_d = '0;
    end else if (strobe_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      state_d  = ST_IDLE;
      drop     = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // Prefix stage: accumulate E0/F0, skip Pause bytes, emit key events.
  always_comb begin
    key_d  = key_q;
    kv_d   = 1'b0;
    fe_d   = drop;
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    if (drop) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (deliver) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (shift_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: rel_d = 1'b1;
          8'hE1: begin
            skip_d = 3'd7;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end
          default: begin
            key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
            kv_d  = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        endcase
      end
    end
  end

  // State registers; synchronisers and filter level reset to bus-idle high.
  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      flt_lvl_q <= 1'b1;
      flt_cnt_q <= '0;
      strobe_q  <= 1'b0;
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      skip_q    <= '0;
      key_q     <= '0;
      kv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      clk_s1_q  <= clk_s1_d;
      clk_s2_q  <= clk_s2_d;
      dat_s1_q  <= dat_s1_d;
      dat_s2_q  <= dat_s2_d;
      flt_lvl_q <= flt_lvl_d;
      flt_cnt_q <= flt_cnt_d;
      strobe_q  <= strobe_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      skip_q    <= skip_d;
      key_q     <= key_d;
      kv_q      <= kv_d;
      fe_q      <= fe_d;
    end
  end

  assign ps2_key   = key_q;
  assign key_valid = kv_q;
  assign frame_err = fe_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: scoreboard bench for ps2_key_rx with directed PS/2 frames.
module tb_ps2_key_rx;

  localparam int FLT  = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 40;

  logic        clk_sys  = 1'b0;
  logic        RESET_L  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_valid;
  logic        frame_err;

  typedef struct packed {
    logic        is_err;
    logic [10:0] key;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [10:0] cur_key = '0;

  always #5 clk_sys = ~clk_sys;

  ps2_key_rx #(.FILTER_LEN(FLT), .TIMEOUT(TMO)) dut (
    .clk_sys   (clk_sys),
    .RESET_L   (RESET_L),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // {stop, odd parity (optionally corrupted), data, start}
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
  endtask

  task automatic expect_key(input logic [10:0] k);
    sb.push_back({1'b0, k});
    cur_key = k;
  endtask

  task automatic expect_err();
    sb.push_back({1'b1, cur_key});
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %03h, required %03h", name, act, req);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 6000) begin
      wait_cyc(1);
      n++;
    end
    wait_cyc(20);
    check({name, "_pending"}, 11'(sb.size()), 11'd0);
    check({name, "_hold"}, ps2_key, cur_key);
  endtask

  initial begin
    RESET_L = 1'b0;
    wait_cyc(5);
    RESET_L = 1'b1;
    wait_cyc(30);
    check("rst_key", ps2_key, 11'h000);
    check("rst_valid", 11'(key_valid), 11'd0);
    check("rst_err", 11'(frame_err), 11'd0);

    fork
      forever begin
        @(negedge clk_sys);
        if (RESET_L && (key_valid || frame_err)) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: key_valid=%0b frame_err=%0b ps2_key=%03h, required no pulse",
                     key_valid, frame_err, ps2_key);
          end else begin
            mon_e = sb.pop_front();
            if (frame_err !== mon_e.is_err || key_valid !== !mon_e.is_err || ps2_key !== mon_e.key) begin
              bad++;
              $display("FAIL event: got valid=%0b err=%0b key=%03h, required valid=%0b err=%0b key=%03h",
                       key_valid, frame_err, ps2_key, !mon_e.is_err, mon_e.is_err, mon_e.key);
            end
          end
        end
      end
    join_none

    // toggle=1 make=1 ext=0 code=1C
    expect_key(11'h61C);
    send_byte(8'h1C);
    drain("make_1c");

    expect_key(11'h01C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain("break_1c");

    expect_key(11'h775);
    send_byte(8'hE0);
    send_byte(8'h75);
    drain("ext_make_75");

    expect_key(11'h175);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    drain("ext_break_75");

`ifdef PS2_PARITY_CHECK_EN
    expect_err();
`else
    expect_key(11'h61C);
`endif
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    drain("bad_parity");

    expect_err();
    send_bits(mk_frame(8'h3A, 1'b0), 5);
    ps2_data = 1'b1;
    wait_cyc(TMO + 10);
    drain("timeout");

`ifdef PS2_PARITY_CHECK_EN
    expect_key(11'h616);
`else
    expect_key(11'h216);
`endif
    send_byte(8'h16);
    drain("after_timeout");

`ifdef PS2_PARITY_CHECK_EN
    expect_key(11'h21C);
`else
    expect_key(11'h61C);
`endif
    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    send_byte(8'h77);
    send_byte(8'h1C);
    drain("pause_skip");

    send_bits(mk_frame(8'h29, 1'b0), 4);
    RESET_L = 1'b0;
    ps2_data = 1'b1;
    wait_cyc(3);
    check("midrst_key", ps2_key, 11'h000);
    check("midrst_valid", 11'(key_valid), 11'd0);
    check("midrst_err", 11'(frame_err), 11'd0);
    wait_cyc(2);
    RESET_L = 1'b1;
    cur_key = '0;
    wait_cyc(30);
    expect_key(11'h629);
    send_byte(8'h29);
    drain("after_reset");

    ps2_data = 1'b0;
    for (int g = 0; g < 6; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
    wait_cyc(50);
    drain("glitch");

    expect_key(11'h25A);
    send_byte(8'h5A);
    drain("after_glitch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
